// File: rtl/ring_router_gateway_mux_pkg.sv
// Shared DII flit and source-id types for the gateway ring router stages.
package ring_router_gateway_mux_pkg;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit;

    typedef enum logic [1:0] {
        SRC_RING  = 2'd0,
        SRC_LOCAL = 2'd1,
        SRC_EXT   = 2'd2
    } dii_src_t;

    localparam int NUM_SRC = 3;

    // Round-robin successor over the three sources.
    function automatic dii_src_t next_src(input dii_src_t s);
        case (s)
            SRC_RING:  next_src = SRC_LOCAL;
            SRC_LOCAL: next_src = SRC_EXT;
            default:   next_src = SRC_RING;
        endcase
    endfunction

endpackage

// File: rtl/dii_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
module dii_rr_arbiter #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt
);

    logic [W-1:0] idx;

    // Walk offsets from far to near so the closest requester to ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

endmodule

// File: rtl/ring_router_gateway_mux.sv
// Gateway ring router output stage: worm-aware 3:1 merge onto one registered ring link.
module ring_router_gateway_mux
    import ring_router_gateway_mux_pkg::*;
#(
    parameter bit RING_PRIORITY = 1'b1,
    parameter int RR_INIT       = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  dii_flit in_ring,
    output logic    in_ring_ready,
    input  dii_flit in_local,
    output logic    in_local_ready,
    input  dii_flit in_ext,
    output logic    in_ext_ready,
    output dii_flit out_ring,
    input  logic    out_ring_ready
);

    localparam logic [1:0] RR_RST_RAW = RR_INIT[1:0];
    localparam dii_src_t   RR_RST     = dii_src_t'(RR_RST_RAW);

    logic       load_en, accept, worm;
    logic       arb_vld, gnt_vld;
    logic [2:0] req;
    logic [1:0] arb_ptr, arb_gnt;
    dii_src_t   gnt, owner, rr_ptr;
    dii_flit    sel;

    assign req     = {in_ext.valid, in_local.valid, in_ring.valid};
    // A zero pointer makes the round-robin arbiter a fixed ring>local>ext priority.
    assign arb_ptr = RING_PRIORITY ? 2'd0 : 2'(rr_ptr);

    dii_rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req     (req),
        .ptr     (arb_ptr),
        .gnt_vld (arb_vld),
        .gnt     (arb_gnt)
    );

    // An open worm pins the grant to its owner, even while the owner bubbles.
    always_comb begin
        if (worm) begin
            gnt     = owner;
            gnt_vld = req[owner];
        end else begin
            gnt     = dii_src_t'(arb_gnt);
            gnt_vld = arb_vld;
        end
    end

    always_comb begin
        case (gnt)
            SRC_LOCAL: sel = in_local;
            SRC_EXT:   sel = in_ext;
            default:   sel = in_ring;
        endcase
    end

    assign load_en        = !out_ring.valid || out_ring_ready;
    assign accept         = rst_n && load_en && gnt_vld;
    assign in_ring_ready  = accept && (gnt == SRC_RING);
    assign in_local_ready = accept && (gnt == SRC_LOCAL);
    assign in_ext_ready   = accept && (gnt == SRC_EXT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_ring <= '0;
            worm     <= 1'b0;
            owner    <= SRC_RING;
            rr_ptr   <= RR_RST;
        end else begin
            if (load_en)
                out_ring <= accept ? '{data: sel.data, last: sel.last, valid: 1'b1} : '0;
            if (accept) begin
                if (sel.last) begin
                    worm <= 1'b0;
                    if (!RING_PRIORITY)
                        rr_ptr <= next_src(gnt);
                end else if (!worm) begin
                    worm  <= 1'b1;
                    owner <= gnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_router_gateway_mux.sv
// Directed bench: strict-priority instance for most steps, round-robin instance for arbitration order.
module tb_ring_router_gateway_mux;
    import ring_router_gateway_mux_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    dii_flit r, l, e, o;
    logic    ord, r_rdy, l_rdy, e_rdy;
    dii_flit r2, l2, e2, o2;
    logic    ord2, r2_rdy, l2_rdy, e2_rdy;
    int      checks = 0;
    int      errors = 0;

    localparam dii_flit IDLE = '0;

    ring_router_gateway_mux #(.RING_PRIORITY(1'b1), .RR_INIT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_ring(r), .in_ring_ready(r_rdy),
        .in_local(l), .in_local_ready(l_rdy),
        .in_ext(e), .in_ext_ready(e_rdy),
        .out_ring(o), .out_ring_ready(ord)
    );

    ring_router_gateway_mux #(.RING_PRIORITY(1'b0), .RR_INIT(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_ring(r2), .in_ring_ready(r2_rdy),
        .in_local(l2), .in_local_ready(l2_rdy),
        .in_ext(e2), .in_ext_ready(e2_rdy),
        .out_ring(o2), .out_ring_ready(ord2)
    );

    always #5 clk = ~clk;

    function automatic dii_flit f(input logic [15:0] d, input logic lst);
        f = '{data: d, last: lst, valid: 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle on the priority DUT: check readies ({ext,local,ring}) before the edge.
    task automatic cyc(input dii_flit rr, ll, ee, input logic rdy, input logic [2:0] exp_rdy,
                       input string tag);
        r = rr; l = ll; e = ee; ord = rdy;
        #2;
        chk({tag, "_rdy"}, {29'd0, e_rdy, l_rdy, r_rdy}, {29'd0, exp_rdy});
        @(posedge clk); #1;
    endtask

    task automatic cyc_rr(input dii_flit rr, ll, ee, input logic [2:0] exp_rdy, input string tag);
        r2 = rr; l2 = ll; e2 = ee; ord2 = 1'b1;
        #2;
        chk({tag, "_rdy"}, {29'd0, e2_rdy, l2_rdy, r2_rdy}, {29'd0, exp_rdy});
        @(posedge clk); #1;
    endtask

    task automatic chk_out(input dii_flit exp, input string tag);
        chk({tag, "_out"}, {14'd0, o}, {14'd0, exp});
    endtask

    task automatic chk_out2(input dii_flit exp, input string tag);
        chk({tag, "_out"}, {14'd0, o2}, {14'd0, exp});
    endtask

    initial begin
        r = IDLE; l = IDLE; e = IDLE; ord = 1'b1;
        r2 = IDLE; l2 = IDLE; e2 = IDLE; ord2 = 1'b1;
        rst_n = 1'b0;

        // 1: reset with every input valid
        for (int i = 0; i < 3; i++)
            cyc(f(16'h1111, 1'b1), f(16'h2222, 1'b0), f(16'h3333, 1'b1), 1'b1, 3'b000, "reset");
        chk_out(IDLE, "reset");
        chk_out2(IDLE, "reset_rr");
        rst_n = 1'b1;
        cyc(IDLE, IDLE, IDLE, 1'b1, 3'b000, "idle");
        chk_out(IDLE, "idle");

        // 2: single local packet
        cyc(IDLE, f(16'h0005, 1'b0), IDLE, 1'b1, 3'b010, "loc0");
        chk_out(f(16'h0005, 1'b0), "loc0");
        cyc(IDLE, f(16'h1234, 1'b0), IDLE, 1'b1, 3'b010, "loc1");
        chk_out(f(16'h1234, 1'b0), "loc1");
        cyc(IDLE, f(16'hBEEF, 1'b1), IDLE, 1'b1, 3'b010, "loc2");
        chk_out(f(16'hBEEF, 1'b1), "loc2");
        cyc(IDLE, IDLE, IDLE, 1'b1, 3'b000, "loc_end");
        chk_out(IDLE, "loc_end");

        // 3a: ring worm, local waits, then follows with no gap
        cyc(f(16'hA000, 1'b0), IDLE, IDLE, 1'b1, 3'b001, "rw0");
        cyc(f(16'hA001, 1'b0), f(16'hB000, 1'b0), IDLE, 1'b1, 3'b001, "rw1");
        cyc(f(16'hA002, 1'b0), f(16'hB000, 1'b0), IDLE, 1'b1, 3'b001, "rw2");
        cyc(f(16'hA003, 1'b1), f(16'hB000, 1'b0), IDLE, 1'b1, 3'b001, "rw3");
        chk_out(f(16'hA003, 1'b1), "rw3");
        cyc(IDLE, f(16'hB000, 1'b0), IDLE, 1'b1, 3'b010, "lw0");
        chk_out(f(16'hB000, 1'b0), "lw0");
        cyc(IDLE, f(16'hB001, 1'b1), IDLE, 1'b1, 3'b010, "lw1");
        chk_out(f(16'hB001, 1'b1), "lw1");

        // 3b: local worm holds the link against higher-priority ring traffic
        cyc(IDLE, f(16'hC000, 1'b0), IDLE, 1'b1, 3'b010, "lk0");
        cyc(f(16'hD000, 1'b1), f(16'hC001, 1'b0), IDLE, 1'b1, 3'b010, "lk1");
        cyc(f(16'hD000, 1'b1), f(16'hC002, 1'b1), IDLE, 1'b1, 3'b010, "lk2");
        chk_out(f(16'hC002, 1'b1), "lk2");
        cyc(f(16'hD000, 1'b1), IDLE, IDLE, 1'b1, 3'b001, "lk3");
        chk_out(f(16'hD000, 1'b1), "lk3");

        // 3c: owner bubble does not let another source in
        cyc(f(16'hE000, 1'b0), IDLE, IDLE, 1'b1, 3'b001, "bub0");
        cyc(IDLE, IDLE, f(16'hF000, 1'b1), 1'b1, 3'b000, "bub1");
        chk_out(IDLE, "bub1");
        cyc(f(16'hE001, 1'b1), IDLE, f(16'hF000, 1'b1), 1'b1, 3'b001, "bub2");
        chk_out(f(16'hE001, 1'b1), "bub2");
        cyc(IDLE, IDLE, f(16'hF000, 1'b1), 1'b1, 3'b100, "bub3");
        chk_out(f(16'hF000, 1'b1), "bub3");

        // 4: strict priority passes only ring while it is valid
        for (int i = 0; i < 3; i++) begin
            cyc(f(16'h0100 + 16'(i), 1'b1), f(16'h0200, 1'b1), f(16'h0300, 1'b1), 1'b1, 3'b001, "prio");
            chk_out(f(16'h0100 + 16'(i), 1'b1), "prio");
        end
        cyc(IDLE, IDLE, IDLE, 1'b1, 3'b000, "prio_end");

        // 4: round robin order ring, local, ext, ring
        cyc_rr(f(16'h0101, 1'b1), f(16'h0201, 1'b1), f(16'h0301, 1'b1), 3'b001, "rr0");
        chk_out2(f(16'h0101, 1'b1), "rr0");
        cyc_rr(f(16'h0102, 1'b1), f(16'h0201, 1'b1), f(16'h0301, 1'b1), 3'b010, "rr1");
        chk_out2(f(16'h0201, 1'b1), "rr1");
        cyc_rr(f(16'h0102, 1'b1), f(16'h0202, 1'b1), f(16'h0301, 1'b1), 3'b100, "rr2");
        chk_out2(f(16'h0301, 1'b1), "rr2");
        cyc_rr(f(16'h0102, 1'b1), f(16'h0202, 1'b1), f(16'h0302, 1'b1), 3'b001, "rr3");
        chk_out2(f(16'h0102, 1'b1), "rr3");
        cyc_rr(IDLE, IDLE, IDLE, 3'b000, "rr_end");

        // 5: backpressure mid-packet
        cyc(IDLE, f(16'h5001, 1'b0), IDLE, 1'b1, 3'b010, "bp0");
        cyc(IDLE, f(16'h5002, 1'b0), IDLE, 1'b1, 3'b010, "bp1");
        for (int i = 0; i < 5; i++) begin
            cyc(IDLE, f(16'h5003, 1'b0), IDLE, 1'b0, 3'b000, "bp_stall");
            chk_out(f(16'h5002, 1'b0), "bp_stall");
        end
        cyc(IDLE, f(16'h5003, 1'b0), IDLE, 1'b1, 3'b010, "bp2");
        chk_out(f(16'h5003, 1'b0), "bp2");
        cyc(IDLE, f(16'h5004, 1'b1), IDLE, 1'b1, 3'b010, "bp3");
        chk_out(f(16'h5004, 1'b1), "bp3");
        cyc(IDLE, IDLE, IDLE, 1'b1, 3'b000, "bp_end");
        chk_out(IDLE, "bp_end");

        // 6: reset mid-worm, then ext is granted at once
        cyc(f(16'h6001, 1'b0), IDLE, IDLE, 1'b1, 3'b001, "rm0");
        cyc(f(16'h6002, 1'b0), IDLE, IDLE, 1'b1, 3'b001, "rm1");
        rst_n = 1'b0;
        cyc(f(16'h6003, 1'b0), IDLE, f(16'h7001, 1'b1), 1'b1, 3'b000, "rm_rst");
        chk_out(IDLE, "rm_rst");
        rst_n = 1'b1;
        cyc(IDLE, IDLE, f(16'h7001, 1'b1), 1'b1, 3'b100, "rm_ext");
        chk_out(f(16'h7001, 1'b1), "rm_ext");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
